io_bit_scheduler: RTL and testbench



---
 rtl/io_seq_pkg.sv | 22 ++
 rtl/io_bit_scheduler_if.sv | 15 +
 rtl/io_bit_scheduler_tick_prescaler.sv | 31 +++
 rtl/io_bit_scheduler.sv | 141 ++++++++++++++
 tb/tb_io_bit_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/io_seq_pkg.sv
// rtl/io_seq_pkg.sv - shared types and constants for the board output bit scheduler
// Contents: output width, bit-address width, auto-pattern mode encodings, engine state enum.
package io_seq_pkg;

    localparam int N_OUT  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'b00,
        MODE_FILL   = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_TICK = 2'b01,
        ST_WR_A      = 2'b10,
        ST_WR_B      = 2'b11
    } state_e;

endpackage

// File: rtl/io_bit_scheduler_if.sv
// rtl/io_bit_scheduler_if.sv - manual bit-write request channel
// Signals: man_valid/man_addr/man_data from the requester, man_ready back from the scheduler.
// master: the manual requester; slave: io_bit_scheduler.
interface io_bit_scheduler_if;
    import io_seq_pkg::*;

    logic              man_valid;
    logic [ADDR_W-1:0] man_addr;
    logic              man_data;
    logic              man_ready;

    modport master (output man_valid, output man_addr, output man_data, input man_ready);
    modport slave  (input man_valid, input man_addr, input man_data, output man_ready);

endinterface

// File: rtl/io_bit_scheduler_tick_prescaler.sv
// rtl/io_bit_scheduler_tick_prescaler.sv - free-running tick divider for the auto engine
// Ports: CLK, RST (sync active-high), en (count while high, clear while low),
//        tick (one-cycle pulse every TICK_DIV enabled cycles).
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Gated by en so a stale terminal count is never seen while disabled.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/io_bit_scheduler.sv
// rtl/io_bit_scheduler.sv - 16-bit board output register shared by manual and auto-pattern writers
// Ports: CLK, RST (sync active-high); man (slave side of the manual write channel);
//        auto_en, auto_mode (00 walk, 01 fill, 10 toggle, 11 no writes);
//        io_out ([7:0] low_io, [15:8] high_io[26..33]); busy (engine not idle); tick (prescaler pulse).
module io_bit_scheduler
    import io_seq_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int N_OUT    = 16
) (
    input  logic               CLK,
    input  logic               RST,
    io_bit_scheduler_if.slave  man,
    input  logic               auto_en,
    input  logic [1:0]         auto_mode,
    output logic [N_OUT-1:0]   io_out,
    output logic               busy,
    output logic               tick
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] pos_q, pos_d, tgt;
    logic              fill_q, fill_d;
    logic              pend_q, pend_d;
    logic              prio_man_q;
    logic [N_OUT-1:0]  io_q;

    logic              auto_req, grant_man, grant_auto;
    logic [ADDR_W-1:0] auto_addr;
    logic              auto_data;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .en   (busy),
        .tick (tick)
    );

    assign busy   = (state_q != ST_IDLE);
    assign io_out = io_q;
    assign tgt    = pos_q + ADDR_W'(1);

    // Only the write states request the port; reserved mode never reaches them.
    assign auto_req = ((state_q == ST_WR_A) && (mode_q != MODE_RSVD)) || (state_q == ST_WR_B);

    // prio_man_q names the side that lost the last contest and so wins the next one.
    assign grant_man     = man.man_valid && (!auto_req || prio_man_q);
    assign grant_auto    = auto_req && (!man.man_valid || !prio_man_q);
    assign man.man_ready = grant_man;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pos_d     = pos_q;
        fill_d    = fill_q;
        pend_d    = pend_q;
        auto_addr = pos_q;
        auto_data = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (auto_en) state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (!auto_en) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end else if (tick || pend_q) begin
                    pend_d = 1'b0;
                    mode_d = mode_e'(auto_mode);
                    if (mode_e'(auto_mode) != MODE_RSVD) state_d = ST_WR_A;
                end
            end
            ST_WR_A: begin
                if (tick) pend_d = 1'b1;
                case (mode_q)
                    MODE_WALK: begin
                        auto_addr = pos_q;
                        auto_data = 1'b0;
                    end
                    MODE_FILL: begin
                        auto_addr = tgt;
                        auto_data = fill_q;
                    end
                    MODE_TOGGLE: begin
                        auto_addr = tgt;
                        auto_data = ~io_q[tgt];
                    end
                    default: state_d = ST_WAIT_TICK;
                endcase
                if (grant_auto) begin
                    if (mode_q == MODE_WALK) begin
                        state_d = ST_WR_B;
                    end else begin
                        pos_d   = tgt;
                        state_d = auto_en ? ST_WAIT_TICK : ST_IDLE;
                        if ((mode_q == MODE_FILL) && (tgt == ADDR_W'(N_OUT - 1))) fill_d = ~fill_q;
                    end
                end
            end
            ST_WR_B: begin
                if (tick) pend_d = 1'b1;
                auto_addr = tgt;
                auto_data = 1'b1;
                // Completing the pair even when auto_en has dropped keeps exactly one hot bit.
                if (grant_auto) begin
                    pos_d   = tgt;
                    state_d = auto_en ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WALK;
            pos_q      <= '1;
            fill_q     <= 1'b1;
            pend_q     <= 1'b0;
            prio_man_q <= 1'b1;
            io_q       <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            if (man.man_valid && auto_req) prio_man_q <= grant_auto;
            if (grant_man) begin
                io_q[man.man_addr] <= man.man_data;
            end else if (grant_auto) begin
                io_q[auto_addr] <= auto_data;
            end
        end
    end

endmodule

// File: tb/tb_io_bit_scheduler.sv
// tb/tb_io_bit_scheduler.sv - scoreboard bench for io_bit_scheduler with TICK_DIV = 4
module tb_io_bit_scheduler;
    import io_seq_pkg::*;

    localparam int SEL_IO    = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_READY = 2;
    localparam int SEL_TICK  = 3;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        auto_en = 1'b0;
    logic [1:0]  auto_mode = 2'b00;
    logic [15:0] io_out;
    logic        busy;
    logic        tick;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    chk_t        sb[$];

    io_bit_scheduler_if bus ();

    io_bit_scheduler #(.TICK_DIV(4), .N_OUT(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .man       (bus),
        .auto_en   (auto_en),
        .auto_mode (auto_mode),
        .io_out    (io_out),
        .busy      (busy),
        .tick      (tick)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expectations are kept ordered by the cycle in which they must hold.
    task automatic push(input int c, input int s, input logic [15:0] e, input string n);
        chk_t item;
        int   i;
        item.cyc  = c;
        item.sel  = s;
        item.exp  = e;
        item.name = n;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, item);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic man_set(input logic v, input logic [3:0] a, input logic d);
        bus.man_valid = v;
        bus.man_addr  = a;
        bus.man_data  = d;
    endtask

    function automatic logic [15:0] fill_exp(input int k);
        logic [31:0] v;
        if (k <= 16) v = (32'd1 << k) - 32'd1;
        else         v = 32'h0000_FFFF << (k - 16);
        return v[15:0];
    endfunction

    always @(negedge CLK) begin
        chk_t        c;
        logic [15:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            c = sb.pop_front();
            case (c.sel)
                SEL_IO:    act = io_out;
                SEL_BUSY:  act = {15'd0, busy};
                SEL_READY: act = {15'd0, bus.man_ready};
                default:   act = {15'd0, tick};
            endcase
            total++;
            if (act !== c.exp || c.cyc != cyc) begin
                bad++;
                $display("FAIL %s cyc=%0d (due %0d) actual=%h required=%h", c.name, cyc, c.cyc, act, c.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        man_set(1'b0, 4'd0, 1'b0);

        push(2, SEL_IO,    16'h0000, "rst_io");
        push(2, SEL_BUSY,  16'h0000, "rst_busy");
        push(2, SEL_TICK,  16'h0000, "rst_tick");
        push(2, SEL_READY, 16'h0001, "man_ready_idle");
        push(3, SEL_IO,    16'h0020, "man_wr5");
        push(4, SEL_IO,    16'h0000, "man_clr5");

        wait_cyc(2);
        RST = 1'b0;
        man_set(1'b1, 4'd5, 1'b1);
        wait_cyc(3);
        man_set(1'b1, 4'd5, 1'b0);

        wait_cyc(4);
        man_set(1'b0, 4'd0, 1'b0);
        push(5, SEL_BUSY, 16'h0001, "walk_busy");
        push(7, SEL_TICK, 16'h0000, "walk_tick_early");
        push(8, SEL_TICK, 16'h0001, "walk_tick_first");
        for (int k = 1; k <= 17; k++)
            push(8 + 4*(k-1) + 3, SEL_IO, 16'(32'd1 << ((k-1) % 16)), $sformatf("walk_t%0d", k));
        auto_mode = 2'b00;
        auto_en   = 1'b1;

        push(78, SEL_BUSY, 16'h0001, "drop_in_wr_b");
        push(79, SEL_IO,   16'h0002, "drop_one_hot");
        push(79, SEL_BUSY, 16'h0000, "drop_idle");
        wait_cyc(77);
        auto_en = 1'b0;

        push(85, SEL_READY, 16'h0001, "cont1_man_wins");
        push(86, SEL_IO,    16'h0102, "cont1_io");
        push(86, SEL_READY, 16'h0000, "cont2_auto_wins");
        push(87, SEL_IO,    16'h0100, "cont2_io");
        push(88, SEL_IO,    16'h0104, "cont_wr_b_io");
        push(90, SEL_IO,    16'h0000, "rst_mid_io");
        push(90, SEL_BUSY,  16'h0000, "rst_mid_busy");
        wait_cyc(80);
        auto_en = 1'b1;
        wait_cyc(85);
        man_set(1'b1, 4'd8, 1'b1);
        wait_cyc(86);
        man_set(1'b1, 4'd9, 1'b1);
        wait_cyc(87);
        man_set(1'b0, 4'd0, 1'b0);
        wait_cyc(89);
        RST     = 1'b1;
        auto_en = 1'b0;

        wait_cyc(90);
        RST = 1'b0;
        push(93, SEL_TICK, 16'h0000, "fill_tick_early");
        push(94, SEL_TICK, 16'h0001, "fill_tick_first");
        for (int k = 1; k <= 32; k++)
            push(94 + 4*(k-1) + 3, SEL_IO, fill_exp(k), $sformatf("fill_t%0d", k));
        push(222, SEL_BUSY, 16'h0000, "fill_stop_idle");
        auto_mode = 2'b01;
        auto_en   = 1'b1;
        wait_cyc(221);
        auto_en = 1'b0;

        wait_cyc(223);
        push(229, SEL_IO,   16'h0000, "rsvd_no_write1");
        push(230, SEL_BUSY, 16'h0001, "rsvd_busy");
        push(232, SEL_IO,   16'h0000, "rsvd_no_write2");
        push(233, SEL_IO,   16'h0002, "tog_preset");
        push(237, SEL_IO,   16'h0003, "tog_t1");
        push(241, SEL_IO,   16'h0001, "tog_t2_clear");
        push(245, SEL_IO,   16'h0005, "tog_t3");
        push(247, SEL_BUSY, 16'h0000, "tog_stop_idle");
        auto_mode = 2'b11;
        auto_en   = 1'b1;
        wait_cyc(232);
        man_set(1'b1, 4'd1, 1'b1);
        auto_mode = 2'b10;
        wait_cyc(233);
        man_set(1'b0, 4'd0, 1'b0);
        wait_cyc(245);
        auto_en = 1'b0;

        wait_cyc(252);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
